// File: rtl/la_lut4cfg_pkg.sv
// rtl/la_lut4cfg_pkg.sv - state encoding and width helper for the la_lut4 config loader
package la_lut4cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Beat-counter width; never below 1 so a single-beat load still has a counter bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/la_lut4cfg.sv
// rtl/la_lut4cfg.sv - beat-stream loader committing N la_lut4 truth tables atomically
// Optional per-beat odd-parity check enabled by LA_LUT4CFG_PARITY_EN.
module la_lut4cfg
    import la_lut4cfg_pkg::*;
#(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter     PROP = "DEFAULT"
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic [DW-1:0]   cfg_data,
`ifdef LA_LUT4CFG_PARITY_EN
    input  logic            cfg_par,
`endif
    output logic            cfg_ready,
    output logic            cfg_done,
    output logic            cfg_loaded,
    output logic            cfg_error,
    output logic [16*N-1:0] lut
);

    localparam int            BEATS = 16 * N / DW;
    localparam int            CW    = clog2(BEATS);
    localparam logic [CW-1:0] LAST  = CW'(BEATS - 1);

    if (PROP != "DEFAULT") begin : g_prop_alt
    end

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   count;
    logic [16*N-1:0] shadow;
    logic            accept;
    logic            beat_bad;
    logic            last_beat;

    assign cfg_ready = (state == LOAD);
    // A start in the same cycle as a beat wins; that beat is dropped.
    assign accept    = cfg_valid & cfg_ready & ~cfg_start;

`ifdef LA_LUT4CFG_PARITY_EN
    assign beat_bad  = accept & ~(^{cfg_data, cfg_par});
`else
    assign beat_bad  = 1'b0;
`endif

    assign last_beat = accept & ~beat_bad & (count == LAST);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cfg_start) state_nxt = LOAD;
            end
            LOAD: begin
                if (cfg_start)      state_nxt = LOAD;
                else if (beat_bad)  state_nxt = IDLE;
                else if (last_beat) state_nxt = COMMIT;
            end
            COMMIT: begin
                state_nxt = cfg_start ? LOAD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count      <= '0;
            shadow     <= '0;
            lut        <= '0;
            cfg_done   <= 1'b0;
            cfg_loaded <= 1'b0;
        end else begin
            cfg_done <= (state == COMMIT);
            if (state == COMMIT) begin
                lut        <= shadow;
                cfg_loaded <= 1'b1;
            end
            if (cfg_start || beat_bad || last_beat) begin
                count <= '0;
            end else if (accept) begin
                count <= count + CW'(1);
            end
            if (accept && !beat_bad) begin
                shadow[int'(count) * DW +: DW] <= cfg_data;
            end
        end
    end

`ifdef LA_LUT4CFG_PARITY_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cfg_error <= 1'b0;
        end else if (cfg_start) begin
            cfg_error <= 1'b0;
        end else if (beat_bad) begin
            cfg_error <= 1'b1;
        end
    end
`else
    assign cfg_error = 1'b0;
`endif

endmodule

// File: tb/tb_la_lut4cfg.sv
// tb/tb_la_lut4cfg.sv - self-checking bench for la_lut4cfg (N=2/DW=8 and N=1/DW=1 instances)
module tb_la_lut4cfg;

    logic        clk    = 1'b0;
    logic        nreset = 1'b0;

    logic        a_start = 1'b0;
    logic        a_valid = 1'b0;
    logic [7:0]  a_data  = 8'h00;
    logic        a_par   = 1'b1;
    logic        a_ready;
    logic        a_done;
    logic        a_loaded;
    logic        a_error;
    logic [31:0] a_lut;

    logic        b_start = 1'b0;
    logic        b_valid = 1'b0;
    logic [0:0]  b_data  = 1'b0;
    logic        b_par   = 1'b1;
    logic        b_ready;
    logic        b_done;
    logic        b_loaded;
    logic        b_error;
    logic [15:0] b_lut;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_lut_a    = 32'h0;
    logic        exp_loaded_a = 1'b0;

    la_lut4cfg #(.N(2), .DW(8), .PROP("DEFAULT")) dut_a (
        .clk        (clk),
        .nreset     (nreset),
        .cfg_start  (a_start),
        .cfg_valid  (a_valid),
        .cfg_data   (a_data),
`ifdef LA_LUT4CFG_PARITY_EN
        .cfg_par    (a_par),
`endif
        .cfg_ready  (a_ready),
        .cfg_done   (a_done),
        .cfg_loaded (a_loaded),
        .cfg_error  (a_error),
        .lut        (a_lut)
    );

    la_lut4cfg #(.N(1), .DW(1), .PROP("DEFAULT")) dut_b (
        .clk        (clk),
        .nreset     (nreset),
        .cfg_start  (b_start),
        .cfg_valid  (b_valid),
        .cfg_data   (b_data),
`ifdef LA_LUT4CFG_PARITY_EN
        .cfg_par    (b_par),
`endif
        .cfg_ready  (b_ready),
        .cfg_done   (b_done),
        .cfg_loaded (b_loaded),
        .cfg_error  (b_error),
        .lut        (b_lut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Odd parity over {data,par}; good=0 deliberately breaks it.
    task automatic drive_a(input logic v, input logic [7:0] d, input bit good);
        a_valid = v;
        a_data  = d;
        a_par   = good ? ~(^d) : (^d);
    endtask

    task automatic check_idle_a(input string tag);
        chk({tag, ":ready"},  32'(a_ready),  32'h0);
        chk({tag, ":lut"},    a_lut,         exp_lut_a);
        chk({tag, ":loaded"}, 32'(a_loaded), 32'(exp_loaded_a));
        chk({tag, ":error"},  32'(a_error),  32'h0);
    endtask

    task automatic partial_a(input int nbeats);
        a_start = 1'b1;
        drive_a(1'b0, 8'($urandom), 1'b1);
        tick();
        a_start = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            drive_a(1'b1, 8'($urandom), 1'b1);
            tick();
        end
        drive_a(1'b0, 8'($urandom), 1'b1);
    endtask

    task automatic load_a(input logic [31:0] word, input int gmin, input int gmax,
                          input bit restart_at_commit, input string tag);
        a_start = 1'b1;
        drive_a(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
        tick();
        a_start = 1'b0;
        chk({tag, ":ready_after_start"}, 32'(a_ready), 32'h1);
        chk({tag, ":error_after_start"}, 32'(a_error), 32'h0);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(gmin, gmax)) begin
                drive_a(1'b0, 8'($urandom), 1'b1);
                tick();
                chk({tag, ":ready_gap"}, 32'(a_ready), 32'h1);
                chk({tag, ":lut_hold"},  a_lut,        exp_lut_a);
            end
            drive_a(1'b1, word[8*k +: 8], 1'b1);
            tick();
        end
        drive_a(1'b0, 8'($urandom), 1'b1);
        chk({tag, ":ready_commit"}, 32'(a_ready), 32'h0);
        chk({tag, ":done_early"},   32'(a_done),  32'h0);
        chk({tag, ":lut_latency"},  a_lut,        exp_lut_a);
        a_start = restart_at_commit;
        tick();
        a_start = 1'b0;
        exp_lut_a    = word;
        exp_loaded_a = 1'b1;
        chk({tag, ":lut"},    a_lut,         exp_lut_a);
        chk({tag, ":done"},   32'(a_done),   32'h1);
        chk({tag, ":loaded"}, 32'(a_loaded), 32'h1);
        chk({tag, ":ready_post"}, 32'(a_ready), restart_at_commit ? 32'h1 : 32'h0);
        if (!restart_at_commit) begin
            tick();
            chk({tag, ":done_once"}, 32'(a_done), 32'h0);
            chk({tag, ":lut_keep"},  a_lut,       exp_lut_a);
        end
    endtask

    initial begin
        logic [31:0] old_lut;
        logic [15:0] b_word;

        // Reset held, then released with no start
        tick();
        chk("rst:lut_a",  a_lut,  32'h0);
        chk("rst:lut_b",  32'(b_lut), 32'h0);
        chk("rst:done_a", 32'(a_done), 32'h0);
        tick();
        nreset = 1'b1;
        tick();
        check_idle_a("s1");
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 8'($urandom), 1'b1);
            tick();
            check_idle_a("s1_ignored");
            chk("s1:done", 32'(a_done), 32'h0);
        end
        drive_a(1'b0, 8'h00, 1'b1);

        // Back-to-back beats: LUT0=AND4, LUT1=OR4
        load_a(32'hFFFE_8000, 0, 0, 1'b0, "s2");
        for (int i = 0; i < 16; i++) begin
            chk("s2:and4", 32'(a_lut[i]),      (i == 15) ? 32'h1 : 32'h0);
            chk("s2:or4",  32'(a_lut[16 + i]), (i != 0)  ? 32'h1 : 32'h0);
        end

        // Valid toggling between beats
        load_a(32'hFFFE_8000, 1, 1, 1'b0, "s3");

        // Restart mid-load; old table held until the new commit
        partial_a(2);
        chk("s4:lut_hold_partial", a_lut, exp_lut_a);
        load_a(32'h4433_2211, 0, 1, 1'b0, "s4");

        // Asynchronous reset mid-load
        partial_a(3);
        #2;
        nreset = 1'b0;
        #1;
        exp_lut_a    = 32'h0;
        exp_loaded_a = 1'b0;
        chk("s5:lut_async",    a_lut,         32'h0);
        chk("s5:loaded_async", 32'(a_loaded), 32'h0);
        chk("s5:ready_async",  32'(a_ready),  32'h0);
        tick();
        nreset = 1'b1;
        tick();
        check_idle_a("s5_idle");
        load_a(32'($urandom), 0, 2, 1'b0, "s5_reload");

        // Start during commit is not lost
        load_a(32'hA5A5_5A5A, 0, 1, 1'b1, "commit_restart");
        load_a(32'h0F0F_F0F0, 0, 1, 1'b0, "after_restart");

        // Randomized loads, restarts and commit-time starts against the model
        for (int it = 0; it < 12; it++) begin
            if (($urandom % 3) == 0) begin
                partial_a($urandom_range(1, 3));
                chk("rnd:lut_hold_partial", a_lut, exp_lut_a);
            end
            load_a(32'($urandom), 0, 3, (it != 11) && (($urandom % 4) == 0), "rnd");
        end
        check_idle_a("rnd_end");

`ifdef LA_LUT4CFG_PARITY_EN
        // Bad parity on the second beat aborts the load
        old_lut = exp_lut_a;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        drive_a(1'b1, 8'($urandom), 1'b1);
        tick();
        drive_a(1'b1, 8'($urandom), 1'b0);
        tick();
        drive_a(1'b0, 8'h00, 1'b1);
        chk("s6:error", 32'(a_error), 32'h1);
        chk("s6:ready", 32'(a_ready), 32'h0);
        tick();
        tick();
        chk("s6:no_done", 32'(a_done),  32'h0);
        chk("s6:lut",     a_lut,        old_lut);
        chk("s6:sticky",  32'(a_error), 32'h1);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("s6:error_clr", 32'(a_error), 32'h0);
        chk("s6:ready_clr", 32'(a_ready), 32'h1);
        load_a(32'h1234_5678, 0, 1, 1'b0, "s6_reload");
`else
        old_lut = exp_lut_a;
        chk("noparity:error", 32'(a_error), 32'h0);
        chk("noparity:lut",   a_lut,        old_lut);
`endif

        // Serial 1-bit stream into a single table: XOR4
        b_word  = 16'h6996;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("s7:ready", 32'(b_ready), 32'h1);
        for (int k = 0; k < 16; k++) begin
            b_valid = 1'b1;
            b_data  = b_word[k];
            b_par   = ~b_word[k];
            tick();
        end
        b_valid = 1'b0;
        chk("s7:done_early", 32'(b_done), 32'h0);
        chk("s7:lut_early",  32'(b_lut),  32'h0);
        tick();
        chk("s7:lut",    32'(b_lut),    32'h6996);
        chk("s7:done",   32'(b_done),   32'h1);
        chk("s7:loaded", 32'(b_loaded), 32'h1);
        chk("s7:error",  32'(b_error),  32'h0);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] sel;
            sel = 4'(i);
            chk("s7:xor4", 32'(b_lut[i]), 32'(^sel));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
